seq_adder_64_ctrl: RTL and testbench
====================================

# seq_adder_64_ctrl

Multi-cycle 64-bit adder controller that reuses one 16-bit ripple-carry slice over four cycles instead of a full 64-bit ripple chain. It captures operands with a valid/ready handshake, steps a slice counter, and chains the carry between slices through a register. It presents the 64-bit sum and carry-out with an output handshake. It sits between operand producers (register file or ALU front end) and result consumers, trading latency for a 4x shorter carry path.

## Interface
- WIDTH, 64, operand and sum width.
- SLICE, 16, adder slice width. WIDTH must be an integer multiple of SLICE.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands A, B, cin are valid.
- in_ready  output  1  controller can accept operands. High only in IDLE.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result, (A + B + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- NSLICE = WIDTH/SLICE = 4. Slice counter idx is log2(NSLICE) = 2 bits wide.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch A, B into operand registers and cin into carry_r. Clear idx. Go to ADD.
  - ADD: the slice adds A_r[idx], B_r[idx] and carry_r. Its sum is written to sum[idx*SLICE +: SLICE] and its carry-out to carry_r; idx then increments. When idx == NSLICE-1, go to DONE and load cout from the slice carry-out.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Operand registers are written only on accept. A and B changing after the accept have no effect on the result.
- in_valid is ignored in ADD and DONE (in_ready=0).
- sum and cout hold their values from DONE until the next accept, and stay readable after the handshake. Upper slices of sum are stale while ADD is in progress.
- Width rule: full-width arithmetic is modulo 2^WIDTH. cout is the true 65th bit.

## Timing
- Reset (asynchronous, any state, including mid-ADD): state=IDLE, idx=0, carry_r=0, sum=0, cout=0, out_valid=0, in_ready=1. Any in-flight operation is discarded; no partial result is ever flagged valid.
- Accept at rising edge E0 (in_valid & in_ready).
- Slices 0..3 are registered at edges E1..E4.
- out_valid rises after E4. Latency from accept to out_valid = NSLICE = 4 cycles.
- If out_ready=1 in the first DONE cycle, the return to IDLE happens at E5, and the earliest next accept is E6. Minimum initiation interval is 6 cycles.
- out_ready held low: DONE persists indefinitely with sum and cout stable.
- in_ready and out_valid are decoded from the state register. They have no combinational path from in_valid or out_ready.

## Structure
- Shared package adder_pkg holds:
  - the FSM state typedef {IDLE, ADD, DONE};
  - the SLICE_W = 16 and NSLICE constants.
- One sub-module is natural: rca_slice_16 (16-bit ripple-carry, ports A, B, cin, sum, cout), built from full adders. It is instantiated once, and its inputs are muxed by idx.
- The controller is purely the FSM, counter, operand/carry/result registers and the slice mux/demux.

## Test plan
- Basic add: A=1005, B=69, cin=1 -> sum=1075, cout=0. out_valid rises exactly 4 cycles after accept.
- Full carry propagation across all slices: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> sum=0, cout=1.
- Cross-slice carry: A=0x0000_0000_FFFF_FFFF, B=1, cin=0 -> sum=0x0000_0001_0000_0000, cout=0.
- Backpressure and input isolation:
  - Stimulus: A=151242, B=53831224, cin=1 accepted. out_ready is held low 3 cycles. During ADD, A, B, in_valid are toggled.
  - Required response: sum=53982467 stable through DONE; in_ready=0 throughout; no second op accepted; return to IDLE on the out_ready edge.
- Reset mid-operation: assert rst during the 2nd ADD cycle. All outputs clear immediately (sum=0, cout=0, out_valid=0, in_ready=1). A following op A=501, B=5002423, cin=0 yields sum=5002924.
- Back-to-back: two ops with out_ready tied high. The second accept occurs 6 cycles after the first, and both results are correct.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the sliced 64-bit adder controller.
package adder_pkg;

  localparam int DATA_W  = 64;
  localparam int SLICE_W = 16;
  localparam int NSLICE  = DATA_W / SLICE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_adder_64_ctrl_if.sv
// Operand/result handshake bundle: master is producer+consumer, slave is the adder.
interface seq_adder_64_ctrl_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DATA_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, A, B, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, A, B, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/rca_slice_16.sv
// Combinational ripple-carry adder slice built from a chain of full adders.
module rca_slice_16
  import adder_pkg::*;
#(
  parameter int W = SLICE_W
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/seq_adder_64_ctrl.sv
// Multi-cycle adder: one SLICE-wide ripple slice reused WIDTH/SLICE times, carry chained
// through carry_r; accept -> out_valid in NSLICE cycles, result held in DONE until out_ready.
module seq_adder_64_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SLICE = SLICE_W
) (
  input  logic                clk,
  input  logic                rst,
  seq_adder_64_ctrl_if.slave  bus
);

  localparam int NS    = WIDTH / SLICE;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [SLICE-1:0] s_a;
  logic [SLICE-1:0] s_b;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;

  assign s_a = a_r[idx*SLICE +: SLICE];
  assign s_b = b_r[idx*SLICE +: SLICE];

  rca_slice_16 #(.W(SLICE)) u_slice (
    .A    (s_a),
    .B    (s_b),
    .cin  (carry_r),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // Handshake outputs are registered alongside the state so neither depends on in_valid/out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.A;
            b_r        <= bus.B;
            carry_r    <= bus.cin;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= ADD;
          end
        end
        ADD: begin
          sum_r[idx*SLICE +: SLICE] <= s_sum;
          carry_r                   <= s_cout;
          idx                       <= idx + 1'b1;
          if (idx == IDX_W'(NS - 1)) begin
            cout_r      <= s_cout;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_seq_adder_64_ctrl.sv
// Directed + random bench for seq_adder_64_ctrl against a plain 65-bit arithmetic model.
module tb_seq_adder_64_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_q[$];
  logic [64:0] res_q[$];

  seq_adder_64_ctrl_if #(.WIDTH(64)) bus ();

  seq_adder_64_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Handshake monitors, sampled at the edge before DUT state updates land.
  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    if (!rst && bus.out_valid && bus.out_ready) res_q.push_back({bus.cout, bus.sum});
    cyc <= cyc + 1;
  end

  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {64'd0, c};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, count latency, optional stall in DONE, release.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input int stall, input bit tog);
    logic [64:0] exp;
    int lat;
    exp = model(a, b, c);
    acc_q.delete();
    chk({tag, "_rdy_idle"}, {64'd0, bus.in_ready}, 65'd1);
    bus.A = a; bus.B = b; bus.cin = c; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) chk({tag, "_rdy_add"}, {64'd0, bus.in_ready}, 65'd0);
      if (tog) begin
        bus.A = {$urandom, $urandom}; bus.B = {$urandom, $urandom};
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 65'(lat), 65'd4);
    chk({tag, "_res"}, {bus.cout, bus.sum}, exp);
    for (int i = 0; i < stall; i++) begin
      if (tog) begin
        bus.in_valid = 1'b1; bus.A = {$urandom, $urandom};
      end
      tick();
      chk({tag, "_hold"}, {bus.in_ready, bus.out_valid, bus.cout, bus.sum[61:0]},
          {1'b0, 1'b1, exp[64], exp[61:0]});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, "_idle"}, {63'd0, bus.in_ready, bus.out_valid}, 65'b10);
    chk({tag, "_kept"}, {bus.cout, bus.sum}, exp);
    chk({tag, "_nacc"}, 65'(acc_q.size()), 65'd1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("reset_state", {bus.cout, bus.sum}, 65'd0);
    chk("reset_hs", {63'd0, bus.in_ready, bus.out_valid}, 65'b10);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_op("basic", 64'd1005, 64'd69, 1'b1, 0, 1'b0);
    do_op("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 1'b0);
    do_op("cross_slice", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0);
    do_op("bp_iso", 64'd151242, 64'd53831224, 1'b1, 3, 1'b1);
    chk("bp_iso_val", 65'd53982467, {bus.cout, bus.sum});

    // Reset during the second ADD cycle, after slice 0 has already landed.
    bus.A = 64'hFFFF_FFFF_FFFF_FFFF; bus.B = 64'hFFFF_FFFF_FFFF_FFFF; bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_res", {bus.cout, bus.sum}, 65'd0);
    chk("rst_mid_hs", {63'd0, bus.in_ready, bus.out_valid}, 65'b10);
    tick();
    rst = 1'b0;
    tick();
    do_op("after_rst", 64'd501, 64'd5002423, 1'b0, 0, 1'b0);

    // Back-to-back with out_ready tied high.
    acc_q.delete(); res_q.delete();
    bus.out_ready = 1'b1;
    bus.A = 64'h1234_5678_9ABC_DEF0; bus.B = 64'hFEDC_BA98_7654_3210; bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.A = 64'h8000_0000_0000_0000; bus.B = 64'h8000_0000_0000_0001; bus.cin = 1'b0;
    for (int i = 0; i < 20 && acc_q.size() < 2; i++) tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && res_q.size() < 2; i++) tick();
    bus.out_ready = 1'b0;
    chk("b2b_nacc", 65'(acc_q.size()), 65'd2);
    chk("b2b_nres", 65'(res_q.size()), 65'd2);
    if (acc_q.size() >= 2) chk("b2b_ii", 65'(acc_q[1] - acc_q[0]), 65'd6);
    if (res_q.size() >= 2) begin
      chk("b2b_res0", res_q[0], model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1));
      chk("b2b_res1", res_q[1], model(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0));
    end
    tick();

    for (int n = 0; n < 20; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_op("rand", ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
